secded_pipeline: RTL
====================

# secded_pipeline

Parametrised SECDED engine that sits between the memory controller's CPU-side datapath and the DFI data bus. It generalises the 72/64 Hsiao engine to any data/check width, with a two-stage registered read-correction pipeline carrying a transaction tag. It adds an armed error-injection path on writes and saturating error counters with a threshold alarm and first-error capture, which feed the ML telemetry block.

## Interface
Parameters:
- DATA_WIDTH, 64: data bits per beat.
- ECC_WIDTH, 8: check bits per beat. Elaboration fails unless DATA_WIDTH ≤ 2^(ECC_WIDTH-1) − ECC_WIDTH.
- TAG_WIDTH, 4: read transaction tag width.
- CNT_WIDTH, 16: error counter width.

Ports (CW = DATA_WIDTH+ECC_WIDTH):
- clk  in  1  sole clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write beat present.
- wr_data  in  DATA_WIDTH  CPU write data.
- dfi_wdata  out  CW  codeword {ecc, data} after any injection.
- dfi_wdata_valid  out  1  dfi_wdata valid.
- inj_arm  in  1  pulse: capture inj_mask and inj_sticky, enter ARMED.
- inj_disarm  in  1  pulse: return to IDLE.
- inj_mask  in  CW  bits XORed onto the outgoing codeword.
- inj_sticky  in  1  0 = one-shot, 1 = every write until disarmed.
- inj_done  out  1  one-cycle pulse when a one-shot injection is applied.
- dfi_rdata  in  CW  raw codeword from DRAM.
- dfi_rdata_valid  in  1  read beat present. No backpressure.
- dfi_rtag  in  TAG_WIDTH  tag carried with the read beat.
- rd_data  out  DATA_WIDTH  corrected data.
- rd_valid / rd_tag  out  1 / TAG_WIDTH  output beat strobe and its tag.
- rd_syndrome  out  ECC_WIDTH  syndrome of this beat.
- rd_err_sbe / rd_err_dbe  out  1 / 1  corrected / uncorrectable flags.
- cnt_clr  in  1  clears counters, alarm and first-error capture.
- sbe_thresh  in  CNT_WIDTH  alarm threshold. 0 disables the alarm.
- sbe_count / dbe_count  out  CNT_WIDTH  saturating event counts.
- sbe_alarm  out  1  sticky; set when sbe_count ≥ sbe_thresh.
- first_err_valid / first_err_tag / first_err_syndrome  out  1 / TAG_WIDTH / ECC_WIDTH  first error (SBE or DBE) since the last clear.

## Operation
- H-matrix columns:
  - Data bit i uses the i-th value, in ascending numeric order, of the ECC_WIDTH-bit values with odd weight ≥ 3. For ECC_WIDTH = 8: 0x07, 0x0B, 0x0D, 0x0E, 0x13, …
  - Check bit j uses the one-hot value 1<<j.
  - Columns are computed by elaboration-time function. No hand tables.
- Encode: ecc[j] is the XOR of every data bit whose column has bit j set. Codeword = {ecc, data} ^ (ARMED ? captured mask : 0).
- Injection FSM:
  - IDLE → ARMED on inj_arm.
  - ARMED + wr_valid: the mask is applied. One-shot returns to IDLE and pulses inj_done. Sticky stays in ARMED.
  - inj_disarm takes priority over inj_arm and over a write's transition. A write in the same cycle as inj_disarm still gets the mask.
  - inj_arm while ARMED recaptures the mask and mode.
- Decode, stage 1 registers: codeword, tag, valid, syndrome = recomputed ecc ^ received ecc.
- Decode, stage 2 registers the outputs:
  - Syndrome 0: clean.
  - Odd weight, matches data column k: flip bit k, sbe = 1.
  - Odd weight, one-hot: check-bit error, data unchanged, sbe = 1.
  - Odd weight, no column match: dbe = 1, data uncorrected.
  - Even nonzero: dbe = 1, data uncorrected.
- rd_err_*, counter updates and first-error capture happen only when the stage-2 valid is set. When invalid, the flags are 0 and rd_data/rd_syndrome hold.
- Counters: increment by 1 and saturate at 2^CNT_WIDTH − 1.
  - cnt_clr in the same cycle as an event: result = 0 + event increment.
  - first_err is captured on that same event.
- Alarm: set when sbe_thresh ≠ 0 and the updated sbe_count ≥ sbe_thresh. Cleared only by cnt_clr or rst.

## Timing
- Reset: every output register is 0 and the FSM is in IDLE. Any in-flight read beats and pending injections are discarded.
- Write latency: 1 cycle, wr_valid at edge N gives dfi_wdata_valid at N+1. dfi_wdata holds when there is no write. inj_done is aligned with dfi_wdata_valid.
- Read latency: 2 cycles, dfi_rdata_valid at edge N gives rd_valid at N+2.
  - Back-to-back beats give one result per cycle.
  - Counters, alarm and first_err update on the same edge as rd_valid.
- inj_arm at edge N applies to a write at edge N+1 or later, not one at N.

## Test plan
- Reset, then write wr_data = 64'h1 → dfi_wdata = {8'h07, 64'h1} one cycle later; loop it back → rd_data = 64'h1, syndrome 0, no flags, latency 2.
- Flip data bit 0 of that codeword → rd_syndrome = 8'h07, rd_err_sbe = 1, rd_data = 64'h1, sbe_count = 1, first_err captured with the tag.
- Flip data bits 0 and 1 → syndrome 8'h0C, rd_err_dbe = 1, data uncorrected, dbe_count = 1. Flip check bit 3 only → syndrome 8'h08, sbe, data intact.
- One-shot arm with mask bit 5 set, then 3 writes → only the first codeword has bit 5 flipped, inj_done pulses once. Sticky mode → every write is flipped until inj_disarm.
- CNT_WIDTH = 3, sbe_thresh = 4, 9 SBE beats back-to-back:
  - sbe_alarm rises with the 4th beat's rd_valid.
  - sbe_count saturates at 7.
  - cnt_clr coincident with an SBE → sbe_count = 1, alarm re-evaluated.
- Assert rst with two read beats in flight and ARMED → no rd_valid afterwards, all outputs 0, the next write is not injected.

Source files
------------

// File: rtl/secded_pipeline.sv
// Parametrised Hsiao SECDED engine: write encoder with armed error injection,
// two-stage read correction pipeline and saturating error telemetry.
module secded_pipeline #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ECC_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0] dfi_wdata,
    output logic                            dfi_wdata_valid,
    input  logic                            inj_arm,
    input  logic                            inj_disarm,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] inj_mask,
    input  logic                            inj_sticky,
    output logic                            inj_done,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0] dfi_rdata,
    input  logic                            dfi_rdata_valid,
    input  logic [TAG_WIDTH-1:0]            dfi_rtag,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_valid,
    output logic [TAG_WIDTH-1:0]            rd_tag,
    output logic [ECC_WIDTH-1:0]            rd_syndrome,
    output logic                            rd_err_sbe,
    output logic                            rd_err_dbe,
    input  logic                            cnt_clr,
    input  logic [CNT_WIDTH-1:0]            sbe_thresh,
    output logic [CNT_WIDTH-1:0]            sbe_count,
    output logic [CNT_WIDTH-1:0]            dbe_count,
    output logic                            sbe_alarm,
    output logic                            first_err_valid,
    output logic [TAG_WIDTH-1:0]            first_err_tag,
    output logic [ECC_WIDTH-1:0]            first_err_syndrome
);

    localparam int unsigned CW = DATA_WIDTH + ECC_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // The code must have enough odd-weight (>=3) columns for every data bit.
    if (DATA_WIDTH > (32'd1 << (ECC_WIDTH - 1)) - ECC_WIDTH) begin : g_bad_width
        $error("secded_pipeline: DATA_WIDTH too large for ECC_WIDTH");
    end

    // idx-th ECC_WIDTH-bit value (ascending) with odd weight >= 3.
    function automatic logic [ECC_WIDTH-1:0] data_col(input int idx);
        logic [ECC_WIDTH-1:0] v;
        int n;
        data_col = '0;
        n = 0;
        for (int c = 0; c < (1 << ECC_WIDTH); c++) begin
            v = ECC_WIDTH'(c);
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1) begin
                if (n == idx) begin
                    data_col = v;
                end
                n++;
            end
        end
    endfunction

    logic [ECC_WIDTH-1:0] h_col [DATA_WIDTH];

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_col
        localparam logic [ECC_WIDTH-1:0] COL = data_col(i);
        assign h_col[i] = COL;
    end

    // Check-bit generation for the write beat and the incoming read beat.
    logic [ECC_WIDTH-1:0] wr_ecc_c;
    logic [ECC_WIDTH-1:0] rd_ecc_c;

    always_comb begin : p_enc
        wr_ecc_c = '0;
        rd_ecc_c = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            if (wr_data[i]) begin
                wr_ecc_c = wr_ecc_c ^ h_col[i];
            end
            if (dfi_rdata[i]) begin
                rd_ecc_c = rd_ecc_c ^ h_col[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Injection FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        INJ_IDLE  = 1'b0,
        INJ_ARMED = 1'b1
    } inj_state_e;

    inj_state_e    state_q;
    inj_state_e    state_d;
    logic [CW-1:0] mask_q;
    logic [CW-1:0] mask_d;
    logic          sticky_q;
    logic          sticky_d;
    logic          inj_apply_c;
    logic          inj_done_c;

    always_ff @(posedge clk) begin : p_inj_state
        if (rst) begin
            state_q  <= INJ_IDLE;
            mask_q   <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin : p_inj_next
        state_d     = state_q;
        mask_d      = mask_q;
        sticky_d    = sticky_q;
        inj_apply_c = 1'b0;
        inj_done_c  = 1'b0;
        case (state_q)
            INJ_IDLE: begin
                if (inj_arm) begin
                    state_d  = INJ_ARMED;
                    mask_d   = inj_mask;
                    sticky_d = inj_sticky;
                end
            end
            INJ_ARMED: begin
                if (wr_valid) begin
                    inj_apply_c = 1'b1;
                    if (!sticky_q) begin
                        state_d    = INJ_IDLE;
                        inj_done_c = 1'b1;
                    end
                end
                if (inj_arm) begin
                    state_d  = INJ_ARMED;
                    mask_d   = inj_mask;
                    sticky_d = inj_sticky;
                end
            end
            default: state_d = INJ_IDLE;
        endcase
        // Disarm wins over arm and over a one-shot completion.
        if (inj_disarm) begin
            state_d = INJ_IDLE;
        end
    end

    always_ff @(posedge clk) begin : p_wr
        if (rst) begin
            dfi_wdata       <= '0;
            dfi_wdata_valid <= 1'b0;
            inj_done        <= 1'b0;
        end else begin
            dfi_wdata_valid <= wr_valid;
            inj_done        <= inj_done_c;
            if (wr_valid) begin
                dfi_wdata <= {wr_ecc_c, wr_data} ^ (inj_apply_c ? mask_q : '0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: capture data, tag and syndrome
    // ------------------------------------------------------------------
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic [ECC_WIDTH-1:0]  s1_syn;

    always_ff @(posedge clk) begin : p_s1
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_tag   <= '0;
            s1_syn   <= '0;
        end else begin
            s1_valid <= dfi_rdata_valid;
            if (dfi_rdata_valid) begin
                s1_data <= dfi_rdata[DATA_WIDTH-1:0];
                s1_tag  <= dfi_rtag;
                s1_syn  <= rd_ecc_c ^ dfi_rdata[CW-1:DATA_WIDTH];
            end
        end
    end

    // Syndrome classification; data columns are odd weight >= 3 so at most one matches.
    logic [DATA_WIDTH-1:0] flip_c;
    logic                  col_hit_c;
    logic                  chk_hit_c;
    logic                  sbe_c;
    logic                  dbe_c;

    always_comb begin : p_dec
        flip_c = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            flip_c[i] = (s1_syn == h_col[i]);
        end
        col_hit_c = |flip_c;
        chk_hit_c = (s1_syn != '0) && ((s1_syn & (s1_syn - ECC_WIDTH'(1))) == '0);
        sbe_c     = col_hit_c | chk_hit_c;
        dbe_c     = (s1_syn != '0) && !sbe_c;
    end

    // Counter, alarm and first-error next values; a clear acts before the event.
    logic                 ev_sbe_c;
    logic                 ev_dbe_c;
    logic [CNT_WIDTH-1:0] sbe_base_c;
    logic [CNT_WIDTH-1:0] dbe_base_c;
    logic [CNT_WIDTH-1:0] sbe_next_c;
    logic [CNT_WIDTH-1:0] dbe_next_c;
    logic                 alarm_next_c;

    always_comb begin : p_cnt
        ev_sbe_c     = s1_valid & sbe_c;
        ev_dbe_c     = s1_valid & dbe_c;
        sbe_base_c   = cnt_clr ? '0 : sbe_count;
        dbe_base_c   = cnt_clr ? '0 : dbe_count;
        sbe_next_c   = (ev_sbe_c && sbe_base_c != CNT_MAX) ? sbe_base_c + CNT_WIDTH'(1) : sbe_base_c;
        dbe_next_c   = (ev_dbe_c && dbe_base_c != CNT_MAX) ? dbe_base_c + CNT_WIDTH'(1) : dbe_base_c;
        alarm_next_c = (!cnt_clr && sbe_alarm) ||
                       ((sbe_thresh != '0) && (sbe_next_c >= sbe_thresh));
    end

    // ------------------------------------------------------------------
    // Read stage 2: registered outputs and telemetry
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_s2
        if (rst) begin
            rd_valid           <= 1'b0;
            rd_data            <= '0;
            rd_tag             <= '0;
            rd_syndrome        <= '0;
            rd_err_sbe         <= 1'b0;
            rd_err_dbe         <= 1'b0;
            sbe_count          <= '0;
            dbe_count          <= '0;
            sbe_alarm          <= 1'b0;
            first_err_valid    <= 1'b0;
            first_err_tag      <= '0;
            first_err_syndrome <= '0;
        end else begin
            rd_valid   <= s1_valid;
            rd_err_sbe <= ev_sbe_c;
            rd_err_dbe <= ev_dbe_c;
            if (s1_valid) begin
                rd_data     <= s1_data ^ flip_c;
                rd_tag      <= s1_tag;
                rd_syndrome <= s1_syn;
            end
            sbe_count <= sbe_next_c;
            dbe_count <= dbe_next_c;
            sbe_alarm <= alarm_next_c;
            if (cnt_clr) begin
                first_err_valid    <= 1'b0;
                first_err_tag      <= '0;
                first_err_syndrome <= '0;
            end
            if ((ev_sbe_c || ev_dbe_c) && (cnt_clr || !first_err_valid)) begin
                first_err_valid    <= 1'b1;
                first_err_tag      <= s1_tag;
                first_err_syndrome <= s1_syn;
            end
        end
    end

endmodule
